// File: rtl/path_query_sequencer_pkg.sv
// Shared types and constants for the two-waypoint path count sequencer:
// widths, FSM state encoding, query indices and the query routing table.
package path_query_sequencer_pkg;

   localparam int DEF_TAG_DW       = 12;
   localparam int DEF_NUM_PATHS_DW = 64;
   localparam int DEF_TIMEOUT_DW   = 20;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_MUL   = 3'd3,
      ST_SUM   = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERR   = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      NODE_SVR = 2'd0,
      NODE_DAC = 2'd1,
      NODE_FFT = 2'd2,
      NODE_OUT = 2'd3
   } node_t;

   typedef struct packed {
      node_t src;
      node_t dst;
   } query_sel_t;

   // Chain A is Q0..Q2, chain B is Q3..Q5.
   localparam logic [2:0] Q_SVR_FFT = 3'd0;
   localparam logic [2:0] Q_FFT_DAC = 3'd1;
   localparam logic [2:0] Q_DAC_OUT = 3'd2;
   localparam logic [2:0] Q_SVR_DAC = 3'd3;
   localparam logic [2:0] Q_DAC_FFT = 3'd4;
   localparam logic [2:0] Q_FFT_OUT = 3'd5;

   // Endpoints of each query in issue order.
   function automatic query_sel_t query_sel(input logic [2:0] idx);
      query_sel_t sel;
      case (idx)
         Q_SVR_FFT: sel = '{src: NODE_SVR, dst: NODE_FFT};
         Q_FFT_DAC: sel = '{src: NODE_FFT, dst: NODE_DAC};
         Q_DAC_OUT: sel = '{src: NODE_DAC, dst: NODE_OUT};
         Q_SVR_DAC: sel = '{src: NODE_SVR, dst: NODE_DAC};
         Q_DAC_FFT: sel = '{src: NODE_DAC, dst: NODE_FFT};
         Q_FFT_OUT: sel = '{src: NODE_FFT, dst: NODE_OUT};
         default:   sel = '{src: NODE_SVR, dst: NODE_FFT};
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/path_query_sequencer_if.sv
// Query/count port between the sequencer (master) and the node network (slave).
interface path_query_sequencer_if
   import path_query_sequencer_pkg::*;
#(
   parameter int TAG_DW       = DEF_TAG_DW,
   parameter int NUM_PATHS_DW = DEF_NUM_PATHS_DW
);
   logic                    query_vld;
   logic [TAG_DW-1:0]       query_src;
   logic [TAG_DW-1:0]       query_dst;
   logic                    query_rdy;
   logic [NUM_PATHS_DW-1:0] count;
   logic                    count_vld;

   modport master (
      output query_vld, query_src, query_dst,
      input  query_rdy, count, count_vld
   );

   modport slave (
      input  query_vld, query_src, query_dst,
      output query_rdy, count, count_vld
   );
endinterface

// File: rtl/path_query_sequencer_mult.sv
// Serial shift-add multiplier: the first partial product is taken on the go
// cycle, the remaining DW-1 on following cycles, so done pulses DW cycles
// after go. The full 2*DW product is kept so the caller can see overflow.
module path_mult #(
   parameter int DW = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            go,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic            done,
   output logic [2*DW-1:0] prod
);
   localparam int CNT_W = $clog2(DW) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW - 1);

   logic [2*DW-1:0] acc_r;
   logic [2*DW-1:0] mcand_r;
   logic [DW-1:0]   mplier_r;
   logic [CNT_W-1:0] cnt_r;
   logic            busy_r;
   logic            done_r;
   logic [2*DW-1:0] first_pp_s;
   logic [2*DW-1:0] step_pp_s;

   // Partial products for the go cycle and for each later step.
   always_comb begin
      first_pp_s = {(2*DW){1'b0}};
      step_pp_s  = {(2*DW){1'b0}};
      if (b[0]) begin
         first_pp_s = {{DW{1'b0}}, a};
      end else begin
         first_pp_s = {(2*DW){1'b0}};
      end
      if (mplier_r[0]) begin
         step_pp_s = mcand_r;
      end else begin
         step_pp_s = {(2*DW){1'b0}};
      end
   end

   // Shift-add datapath and step counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r    <= {(2*DW){1'b0}};
         mcand_r  <= {(2*DW){1'b0}};
         mplier_r <= {DW{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else if (go) begin
         acc_r    <= first_pp_s;
         mcand_r  <= {{(DW-1){1'b0}}, a, 1'b0};
         mplier_r <= b >> 1;
         cnt_r    <= CNT_W'(1);
         busy_r   <= 1'b1;
         done_r   <= 1'b0;
      end else if (busy_r) begin
         acc_r    <= acc_r + step_pp_s;
         mcand_r  <= mcand_r << 1;
         mplier_r <= mplier_r >> 1;
         cnt_r    <= cnt_r + CNT_W'(1);
         busy_r   <= (cnt_r != CNT_LAST);
         done_r   <= (cnt_r == CNT_LAST);
      end else begin
         done_r   <= 1'b0;
      end
   end

   assign done = done_r;
   assign prod = acc_r;
endmodule

// File: rtl/path_query_sequencer.sv
// Issues the six (src,dst) path count queries of the two waypoint chains,
// multiplies the counts of each chain serially, skips the rest of a chain
// once its product is zero, and reports chainA + chainB.
module path_query_sequencer
   import path_query_sequencer_pkg::*;
#(
   parameter int NUM_PATHS_DW = DEF_NUM_PATHS_DW,
   parameter int TAG_DW       = DEF_TAG_DW,
   parameter int TIMEOUT_DW   = DEF_TIMEOUT_DW
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [TAG_DW-1:0]       svr_tag,
   input  logic [TAG_DW-1:0]       dac_tag,
   input  logic [TAG_DW-1:0]       fft_tag,
   input  logic [TAG_DW-1:0]       out_tag,
   path_query_sequencer_if.master  net,
   output logic                    busy,
   output logic [NUM_PATHS_DW-1:0] result,
   output logic                    result_vld,
   output logic                    overflow,
   output logic                    error
);
   localparam int DW = NUM_PATHS_DW;
   localparam logic [TIMEOUT_DW-1:0] WD_LAST = {{(TIMEOUT_DW-1){1'b1}}, 1'b0};

   state_t            state_r;
   logic [TAG_DW-1:0] svr_tag_r, dac_tag_r, fft_tag_r, out_tag_r;
   logic [2:0]        qidx_r;
   logic [TIMEOUT_DW-1:0] wdog_r;
   logic [DW-1:0]     prod_a_r, prod_b_r;
   logic              query_vld_r;
   logic [TAG_DW-1:0] query_src_r, query_dst_r;
   logic              busy_r, result_vld_r, overflow_r, error_r;
   logic [DW-1:0]     result_r;

   logic              mult_go_s, mult_done_s;
   logic [2*DW-1:0]   mult_prod_s;
   logic [DW-1:0]     mult_a_s, mul_low_s;
   logic              mul_ovf_s, chain_b_s, chain_first_s, to_sum_s;
   logic [2:0]        next_qidx_s;
   logic [DW:0]       sum_s;
   query_sel_t        first_sel_s, next_sel_s;

   function automatic logic [TAG_DW-1:0] tag_of(input node_t n,
      input logic [TAG_DW-1:0] s, input logic [TAG_DW-1:0] d,
      input logic [TAG_DW-1:0] f, input logic [TAG_DW-1:0] o);
      case (n)
         NODE_SVR: return s;
         NODE_DAC: return d;
         NODE_FFT: return f;
         NODE_OUT: return o;
         default:  return s;
      endcase
   endfunction

   // Multiplier operands, chain bookkeeping, zero-skip routing and final sum.
   always_comb begin
      chain_b_s     = (qidx_r >= Q_SVR_DAC);
      chain_first_s = (qidx_r == Q_SVR_FFT) || (qidx_r == Q_SVR_DAC);
      mult_go_s     = (state_r == ST_WAIT) && net.count_vld;
      if (chain_first_s) begin
         mult_a_s = {{(DW-1){1'b0}}, 1'b1};
      end else if (chain_b_s) begin
         mult_a_s = prod_b_r;
      end else begin
         mult_a_s = prod_a_r;
      end
      mul_low_s = mult_prod_s[DW-1:0];
      mul_ovf_s = |mult_prod_s[2*DW-1:DW];
      if (qidx_r == Q_FFT_OUT) begin
         to_sum_s    = 1'b1;
         next_qidx_s = qidx_r;
      end else if (mul_low_s == {DW{1'b0}}) begin
         to_sum_s    = chain_b_s;
         next_qidx_s = chain_b_s ? qidx_r : Q_SVR_DAC;
      end else begin
         to_sum_s    = 1'b0;
         next_qidx_s = qidx_r + 3'd1;
      end
      first_sel_s = query_sel(Q_SVR_FFT);
      next_sel_s  = query_sel(next_qidx_s);
      sum_s       = {1'b0, prod_a_r} + {1'b0, prod_b_r};
   end

   path_mult #(.DW(DW)) u_mult (
      .clk  (clk),
      .rst_n(rst_n),
      .go   (mult_go_s),
      .a    (mult_a_s),
      .b    (net.count),
      .done (mult_done_s),
      .prod (mult_prod_s)
   );

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         svr_tag_r    <= {TAG_DW{1'b0}};
         dac_tag_r    <= {TAG_DW{1'b0}};
         fft_tag_r    <= {TAG_DW{1'b0}};
         out_tag_r    <= {TAG_DW{1'b0}};
         qidx_r       <= Q_SVR_FFT;
         wdog_r       <= {TIMEOUT_DW{1'b0}};
         prod_a_r     <= {DW{1'b0}};
         prod_b_r     <= {DW{1'b0}};
         query_vld_r  <= 1'b0;
         query_src_r  <= {TAG_DW{1'b0}};
         query_dst_r  <= {TAG_DW{1'b0}};
         busy_r       <= 1'b0;
         result_r     <= {DW{1'b0}};
         result_vld_r <= 1'b0;
         overflow_r   <= 1'b0;
         error_r      <= 1'b0;
      end else begin
         result_vld_r <= 1'b0;
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  svr_tag_r   <= svr_tag;
                  dac_tag_r   <= dac_tag;
                  fft_tag_r   <= fft_tag;
                  out_tag_r   <= out_tag;
                  qidx_r      <= Q_SVR_FFT;
                  prod_a_r    <= {DW{1'b0}};
                  prod_b_r    <= {DW{1'b0}};
                  overflow_r  <= 1'b0;
                  busy_r      <= 1'b1;
                  query_vld_r <= 1'b1;
                  query_src_r <= tag_of(first_sel_s.src, svr_tag, dac_tag, fft_tag, out_tag);
                  query_dst_r <= tag_of(first_sel_s.dst, svr_tag, dac_tag, fft_tag, out_tag);
                  state_r     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (net.query_rdy) begin
                  query_vld_r <= 1'b0;
                  wdog_r      <= {TIMEOUT_DW{1'b0}};
                  state_r     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (net.count_vld) begin
                  state_r <= ST_MUL;
               end else if (wdog_r == WD_LAST) begin
                  wdog_r  <= wdog_r + TIMEOUT_DW'(1);
                  error_r <= 1'b1;
                  state_r <= ST_ERR;
               end else begin
                  wdog_r  <= wdog_r + TIMEOUT_DW'(1);
               end
            end
            ST_MUL: begin
               if (mult_done_s) begin
                  if (chain_b_s) begin
                     prod_b_r <= mul_low_s;
                  end else begin
                     prod_a_r <= mul_low_s;
                  end
                  overflow_r <= overflow_r | mul_ovf_s;
                  if (to_sum_s) begin
                     state_r <= ST_SUM;
                  end else begin
                     qidx_r      <= next_qidx_s;
                     query_vld_r <= 1'b1;
                     query_src_r <= tag_of(next_sel_s.src, svr_tag_r, dac_tag_r, fft_tag_r, out_tag_r);
                     query_dst_r <= tag_of(next_sel_s.dst, svr_tag_r, dac_tag_r, fft_tag_r, out_tag_r);
                     state_r     <= ST_ISSUE;
                  end
               end
            end
            ST_SUM: begin
               result_r     <= sum_s[DW-1:0];
               overflow_r   <= overflow_r | sum_s[DW];
               result_vld_r <= 1'b1;
               busy_r       <= 1'b0;
               state_r      <= ST_DONE;
            end
            ST_ERR: begin
               state_r <= ST_ERR;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign net.query_vld = query_vld_r;
   assign net.query_src = query_src_r;
   assign net.query_dst = query_dst_r;
   assign busy          = busy_r;
   assign result        = result_r;
   assign result_vld    = result_vld_r;
   assign overflow      = overflow_r;
   assign error         = error_r;
endmodule

// File: tb/tb_path_query_sequencer.sv
// Directed bench: a network responder answers queries from a per-test count
// table; a chain-product model predicts query order, result and overflow.
module tb_path_query_sequencer;
   localparam int DW  = 64;
   localparam int TW  = 12;
   localparam int TOW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [TW-1:0] svr_tag = 12'h101;
   logic [TW-1:0] dac_tag = 12'h2A2;
   logic [TW-1:0] fft_tag = 12'h3F3;
   logic [TW-1:0] out_tag = 12'h404;
   logic          busy, result_vld, overflow, error;
   logic [DW-1:0] result;

   path_query_sequencer_if #(.TAG_DW(TW), .NUM_PATHS_DW(DW)) net();

   path_query_sequencer #(.NUM_PATHS_DW(DW), .TAG_DW(TW), .TIMEOUT_DW(TOW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .svr_tag(svr_tag), .dac_tag(dac_tag), .fft_tag(fft_tag), .out_tag(out_tag),
      .net(net), .busy(busy), .result(result), .result_vld(result_vld),
      .overflow(overflow), .error(error)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] cnt_tbl [6];
   logic [TW-1:0] exp_src [6];
   logic [TW-1:0] exp_dst [6];
   int            exp_q [$];
   logic [DW-1:0] exp_result;
   logic          exp_ovf;
   int            pulses = 0;
   int            stall_seen = 0;
   bit            no_resp = 1'b0;
   bit            hold_en = 1'b0;
   int            hold_cnt = 0;
   int            resp_idx;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   function automatic int lookup(input logic [TW-1:0] s, input logic [TW-1:0] d);
      for (int i = 0; i < 6; i++)
         if (exp_src[i] == s && exp_dst[i] == d) return i;
      return -1;
   endfunction

   // Chain products with early stop on zero, sum, overflow on any lost bit.
   task automatic model();
      logic [127:0] full;
      logic [63:0]  a, b;
      logic [64:0]  s;
      exp_q.delete();
      exp_ovf = 1'b0;
      a = 64'd1;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(i);
         full = {64'd0, a} * {64'd0, cnt_tbl[i]};
         if (full[127:64] != 64'd0) exp_ovf = 1'b1;
         a = full[63:0];
         if (a == 64'd0) break;
      end
      b = 64'd1;
      for (int i = 3; i < 6; i++) begin
         exp_q.push_back(i);
         full = {64'd0, b} * {64'd0, cnt_tbl[i]};
         if (full[127:64] != 64'd0) exp_ovf = 1'b1;
         b = full[63:0];
         if (b == 64'd0) break;
      end
      s = {1'b0, a} + {1'b0, b};
      if (s[64]) exp_ovf = 1'b1;
      exp_result = s[63:0];
   endtask

   // Network responder: ready control, then count strobe one cycle after handshake.
   always begin
      @(posedge clk);
      #1;
      if (rst_n && net.query_vld) begin
         if (hold_en && net.query_src == dac_tag && net.query_dst == out_tag && hold_cnt < 10) begin
            net.query_rdy = 1'b0;
            hold_cnt++;
         end else begin
            net.query_rdy = 1'b1;
            resp_idx = lookup(net.query_src, net.query_dst);
            @(posedge clk);
            if (!no_resp && resp_idx >= 0) begin
               #1;
               net.count     = cnt_tbl[resp_idx];
               net.count_vld = 1'b1;
               @(posedge clk);
               #1;
               net.count_vld = 1'b0;
            end
         end
      end else begin
         net.query_rdy = 1'b1;
      end
   end

   // Compare process: query order/stability every cycle, result on each pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         if (net.query_vld) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_query: got src=%0h dst=%0h, required no query", net.query_src, net.query_dst);
            end else begin
               check("query_src", 64'(net.query_src), 64'(exp_src[exp_q[0]]));
               check("query_dst", 64'(net.query_dst), 64'(exp_dst[exp_q[0]]));
               if (net.query_rdy) void'(exp_q.pop_front());
               else stall_seen++;
            end
         end
         if (result_vld) begin
            pulses++;
            check("result", result, exp_result);
            check("overflow", 64'(overflow), 64'(exp_ovf));
            check("error_at_result", 64'(error), 64'd0);
            check("busy_at_result", 64'(busy), 64'd0);
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_case(input logic [63:0] c0, input logic [63:0] c1, input logic [63:0] c2,
                           input logic [63:0] c3, input logic [63:0] c4, input logic [63:0] c5,
                           output int lat);
      bit got;
      cnt_tbl[0] = c0; cnt_tbl[1] = c1; cnt_tbl[2] = c2;
      cnt_tbl[3] = c3; cnt_tbl[4] = c4; cnt_tbl[5] = c5;
      model();
      pulses = 0;
      stall_seen = 0;
      got = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      lat = 1;
      #1;
      start = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (result_vld) begin
            got = 1'b1;
            break;
         end
         @(posedge clk);
         lat++;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL result_timeout: got no result_vld, required one within 3000 cycles");
      end
      repeat (3) @(negedge clk);
      check("result_pulses", 64'(pulses), 64'd1);
      check("queries_left", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int lat;
      int n;
      bit seen;
      exp_src[0] = svr_tag; exp_dst[0] = fft_tag;
      exp_src[1] = fft_tag; exp_dst[1] = dac_tag;
      exp_src[2] = dac_tag; exp_dst[2] = out_tag;
      exp_src[3] = svr_tag; exp_dst[3] = dac_tag;
      exp_src[4] = dac_tag; exp_dst[4] = fft_tag;
      exp_src[5] = fft_tag; exp_dst[5] = out_tag;
      net.query_rdy = 1'b1;
      net.count     = 64'd0;
      net.count_vld = 1'b0;
      exp_result    = 64'd0;
      exp_ovf       = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_query_vld", 64'(net.query_vld), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_result", result, 64'd0);
      check("rst_result_vld", 64'(result_vld), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      rst_n = 1'b1;

      // Chain B dies at Q4, Q5 never issued; 5 queries of 66 cycles + SUM.
      run_case(64'd2, 64'd3, 64'd4, 64'd5, 64'd0, 64'd9, lat);
      check("t1_model", exp_result, 64'd24);
      check("t1_result", result, 64'd24);
      check("t1_overflow", 64'(overflow), 64'd0);
      check("t1_latency", 64'(lat), 64'd332);

      // Chain A dies at Q0, jump to Q3.
      run_case(64'd0, 64'd9, 64'd9, 64'd1, 64'd7, 64'd3, lat);
      check("t2_result", result, 64'd21);

      // 2^32 * 2^32 wraps to zero with overflow, Q2 skipped, Q3 zero.
      run_case(64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 64'd0, 64'd5, 64'd5, lat);
      check("t3_result", result, 64'd0);
      check("t3_overflow", 64'(overflow), 64'd1);
      check("t3_error", 64'(error), 64'd0);

      // Backpressure on Q2 for 10 cycles; restart also clears overflow.
      hold_en = 1'b1;
      hold_cnt = 0;
      run_case(64'd2, 64'd3, 64'd4, 64'd5, 64'd0, 64'd9, lat);
      hold_en = 1'b0;
      check("t4_stall_cycles", 64'(stall_seen), 64'd10);
      check("t4_result", result, 64'd24);
      check("t4_overflow_cleared", 64'(overflow), 64'd0);
      check("t4_latency", 64'(lat), 64'd342);

      // Reset during the multiply of Q1, then a fresh run.
      cnt_tbl[0] = 64'd2; cnt_tbl[1] = 64'd3; cnt_tbl[2] = 64'd4;
      cnt_tbl[3] = 64'd5; cnt_tbl[4] = 64'd0; cnt_tbl[5] = 64'd9;
      model();
      pulse_start();
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (exp_q.size() == 3) begin
            seen = 1'b1;
            break;
         end
      end
      check("t6_q1_issued", 64'(seen), 64'd1);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("t6_rst_query_vld", 64'(net.query_vld), 64'd0);
      check("t6_rst_busy", 64'(busy), 64'd0);
      check("t6_rst_result", result, 64'd0);
      check("t6_rst_overflow", 64'(overflow), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_case(64'd1, 64'd1, 64'd1, 64'd0, 64'd5, 64'd5, lat);
      check("t6_result", result, 64'd1);

      // Watchdog: Q0 never answered, error after 15 waiting cycles.
      no_resp = 1'b1;
      cnt_tbl[0] = 64'd2;
      exp_q.delete();
      exp_q.push_back(0);
      pulses = 0;
      pulse_start();
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (net.query_vld && net.query_rdy) begin
            seen = 1'b1;
            break;
         end
      end
      check("t5_q0_issued", 64'(seen), 64'd1);
      @(posedge clk);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (error) break;
         n++;
         @(posedge clk);
      end
      check("t5_timeout_cycles", 64'(n), 64'd15);
      repeat (10) @(negedge clk);
      pulse_start();
      repeat (10) @(negedge clk);
      check("t5_error", 64'(error), 64'd1);
      check("t5_busy", 64'(busy), 64'd1);
      check("t5_query_vld", 64'(net.query_vld), 64'd0);
      check("t5_pulses", 64'(pulses), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
